// File: rtl/uart_pkg.sv
`default_nettype none
// ==========================================================================
// Module   : uart_pkg
// Summary  : Shared UART link types and oversample divisor helper.
// Revision : 1.0
// ==========================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    NOPARITY00 = 2'b00,
    ODD        = 2'b01,
    EVEN       = 2'b10,
    NOPARITY11 = 2'b11
  } parity_bit_t;

  typedef enum logic [1:0] {
    BAUD24  = 2'b00,
    BAUD48  = 2'b01,
    BAUD96  = 2'b10,
    BAUD192 = 2'b11
  } baud_rate_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_IDLE = 3'd5
  } rx_state_t;

  // Rounded clock cycles per oversample tick (16 ticks per bit).
  function automatic int oversample_div(input baud_rate_t baud, input int clk_freq);
    int bps;
    case (baud)
      BAUD24:  bps = 2400;
      BAUD48:  bps = 4800;
      BAUD96:  bps = 9600;
      default: bps = 19200;
    endcase
    return (clk_freq + 8 * bps) / (16 * bps);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_baud_gen.sv
`default_nettype none
// ==========================================================================
// Module   : uart_rx_baud_gen
// Summary  : Oversample tick generator; counter held at zero while disabled.
// Revision : 1.0
// ==========================================================================
module uart_rx_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  baud_rate_t baud_rate,
  output logic       tick
);

  localparam int c_DIV_MAX = oversample_div(BAUD24, CLK_FREQ);
  localparam int CW        = $clog2(c_DIV_MAX + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_last;

  always_comb w_last = CW'(oversample_div(baud_rate, CLK_FREQ) - 1);

  assign tick = enable && (r_cnt == w_last);

  always_ff @(posedge clock) begin
    if (reset || !enable || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_unit.sv
`default_nettype none
// ==========================================================================
// Module   : uart_rx_unit
// Summary  : 16x oversampled UART receiver with 3-sample majority vote.
// Revision : 1.0
// ==========================================================================
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_rx,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       done_flag,
  output logic       parity_error,
  output logic       framing_error,
  output logic       active_flag
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] c_SMP_FIRST  = TW'(7);
  localparam logic [TW-1:0] c_SMP_SECOND = TW'(8);
  localparam logic [TW-1:0] c_RESOLVE    = TW'(9);
  localparam logic [TW-1:0] c_LAST       = TW'(OVERSAMPLE - 1);

  rx_state_t   r_state, w_state_nxt;
  logic [1:0]  r_sync;
  logic        r_rx_prev;
  logic [TW-1:0] r_tcnt;
  logic [1:0]  r_smp;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_par_bit;
  baud_rate_t  r_baud;
  parity_bit_t r_parity;
  logic [7:0]  r_data_out;
  logic        r_done, r_perr, r_ferr, r_active;

  logic          w_rx, w_tick, w_enable, w_fall, w_majority;
  logic          w_resolve, w_bit_end, w_par_en, w_par_exp;
  logic          w_start_ok, w_frame_end;
  logic [TW-1:0] w_tcnt_nxt;

  assign w_rx       = r_sync[1];
  assign w_fall     = r_rx_prev & ~w_rx;
  assign w_enable   = (r_state != RX_IDLE) && (r_state != RX_WAIT_IDLE);
  assign w_tcnt_nxt = r_tcnt + TW'(1);
  // Samples land on ticks 7/8/9 of the bit; the vote completes on tick 9.
  assign w_resolve  = w_tick && (w_tcnt_nxt == c_RESOLVE);
  assign w_bit_end  = w_tick && (r_tcnt == c_LAST);
  assign w_majority = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx) | (r_smp[1] & w_rx);
  assign w_par_en   = (r_parity == ODD) || (r_parity == EVEN);
  assign w_par_exp  = (r_parity == EVEN) ? ^r_shift : ~^r_shift;

  uart_rx_baud_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_baud_gen (
    .clock     (clock),
    .reset     (reset),
    .enable    (w_enable),
    .baud_rate (r_baud),
    .tick      (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_fall) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (w_resolve) begin
          if (w_majority) w_state_nxt = RX_IDLE;
          else            w_start_ok  = 1'b1;
        end else if (w_bit_end) begin
          w_state_nxt = RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = w_par_en ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: begin
        if (w_bit_end) w_state_nxt = RX_STOP;
      end
      RX_STOP: begin
        if (w_resolve) begin
          w_frame_end = 1'b1;
          w_state_nxt = w_majority ? RX_IDLE : RX_WAIT_IDLE;
        end
      end
      RX_WAIT_IDLE: begin
        if (w_rx) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= RX_IDLE;
      r_sync     <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_tcnt     <= '0;
      r_smp      <= 2'b00;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_par_bit  <= 1'b0;
      r_baud     <= BAUD24;
      r_parity   <= NOPARITY00;
      r_data_out <= 8'h00;
      r_done     <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], data_rx};
      r_rx_prev <= w_rx;
      r_state   <= w_state_nxt;
      r_done    <= w_frame_end;

      if (r_state == RX_IDLE) r_tcnt <= '0;
      else if (w_tick)        r_tcnt <= w_tcnt_nxt;

      if (w_tick && (w_tcnt_nxt == c_SMP_FIRST))  r_smp[0] <= w_rx;
      if (w_tick && (w_tcnt_nxt == c_SMP_SECOND)) r_smp[1] <= w_rx;

      // Link configuration is frozen for the whole frame.
      if ((r_state == RX_IDLE) && w_fall) begin
        r_baud   <= baud_rate_t'(baud_rate);
        r_parity <= parity_bit_t'(parity_type);
      end

      if (r_state == RX_START)                   r_bit_idx <= 3'd0;
      else if ((r_state == RX_DATA) && w_bit_end) r_bit_idx <= r_bit_idx + 3'd1;

      if ((r_state == RX_DATA) && w_resolve)   r_shift   <= {w_majority, r_shift[7:1]};
      if ((r_state == RX_PARITY) && w_resolve) r_par_bit <= w_majority;

      if (w_start_ok)       r_active <= 1'b1;
      else if (w_frame_end) r_active <= 1'b0;

      if (w_frame_end) begin
        r_data_out <= r_shift;
        r_ferr     <= ~w_majority;
        r_perr     <= w_par_en && (r_par_bit != w_par_exp);
      end
    end
  end

  assign data_out      = r_data_out;
  assign done_flag     = r_done;
  assign parity_error  = r_perr;
  assign framing_error = r_ferr;
  assign active_flag   = r_active;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ==========================================================================
// Module   : tb_uart_rx_unit
// Summary  : Scoreboard bench for uart_rx_unit, directed frames.
// Revision : 1.0
// ==========================================================================
module tb_uart_rx_unit;

  // Reduced clock keeps 2400 baud frames short; divisors are round(3.2e6/(16*baud)).
  localparam int CLK_FREQ  = 3_200_000;
  localparam int DIV2400   = 83;
  localparam int DIV4800   = 42;
  localparam int DIV9600   = 21;
  localparam int DIV19200  = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       data_rx = 1'b1;
  logic [1:0] baud_rate = 2'b00;
  logic [1:0] parity_type = 2'b00;
  logic [7:0] data_out;
  logic       done_flag, parity_error, framing_error, active_flag;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   last_done_cyc = 0;
  int   start_cyc = 0;

  uart_rx_unit #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .data_rx       (data_rx),
    .baud_rate     (baud_rate),
    .parity_type   (parity_type),
    .data_out      (data_out),
    .done_flag     (done_flag),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .active_flag   (active_flag)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    sb.push_back(e);
  endtask

  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (done_flag) begin
        done_count++;
        last_done_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=%0h required=none", data_out);
        end else begin
          e = sb.pop_front();
          chk("data_out", 32'(data_out), 32'(e.d));
          chk("parity_error", 32'(parity_error), 32'(e.pe));
          chk("framing_error", 32'(framing_error), 32'(e.fe));
        end
      end
    end
  endtask

  task automatic drive_bit(input logic v, input int div);
    data_rx = v;
    repeat (16 * div) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input int div, input logic par_en,
                            input logic pbit, input logic stop);
    start_cyc = cyc;
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++) drive_bit(d[i], div);
    if (par_en) drive_bit(pbit, div);
    drive_bit(stop, div);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'h0);
    chk({tag, "_done"}, 32'(done_flag), 32'h0);
    chk({tag, "_perr"}, 32'(parity_error), 32'h0);
    chk({tag, "_ferr"}, 32'(framing_error), 32'h0);
    chk({tag, "_active"}, 32'(active_flag), 32'h0);
  endtask

  initial begin
    int   n;
    logic saw_active;
    logic [7:0] c3;

    fork
      sb_monitor();
    join_none

    repeat (4) @(negedge clock);
    chk_idle_outputs("reset");
    reset = 1'b0;
    drive_bit(1'b1, DIV9600);

    // 9600 odd, 0xAA: odd parity bit = 1
    baud_rate = 2'b10; parity_type = 2'b01;
    n = done_count;
    push_exp(8'hAA, 1'b0, 1'b0);
    send_frame(8'hAA, DIV9600, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, DIV9600);
    chk("t1_done_count", 32'(done_count), 32'(n + 1));
    chk_range("t1_latency", last_done_cyc - start_cyc, 168 * DIV9600, 169 * DIV9600 + 5);

    // 19200 even, 0xAA: even parity bit = 0; active window probed
    baud_rate = 2'b11; parity_type = 2'b10;
    n = done_count;
    push_exp(8'hAA, 1'b0, 1'b0);
    fork
      send_frame(8'hAA, DIV19200, 1'b1, 1'b0, 1'b1);
      begin
        repeat (4 * DIV19200) @(negedge clock);
        chk("t2_active_pre", 32'(active_flag), 32'h0);
        repeat (44 * DIV19200) @(negedge clock);
        chk("t2_active_mid", 32'(active_flag), 32'h1);
      end
    join
    chk("t2_active_post", 32'(active_flag), 32'h0);
    drive_bit(1'b1, DIV19200);
    chk("t2_done_count", 32'(done_count), 32'(n + 1));
    chk_range("t2_latency", last_done_cyc - start_cyc, 168 * DIV19200, 169 * DIV19200 + 5);

    // 9600 odd, 0x0F with wrong parity bit 0 (odd needs 1); mid-frame config change ignored
    baud_rate = 2'b10; parity_type = 2'b01;
    push_exp(8'h0F, 1'b1, 1'b0);
    fork
      send_frame(8'h0F, DIV9600, 1'b1, 1'b0, 1'b1);
      begin
        repeat (40 * DIV9600) @(negedge clock);
        parity_type = 2'b10;
        baud_rate   = 2'b11;
      end
    join
    drive_bit(1'b1, DIV9600);

    // 4800 none, 0x55 with low stop bit, line held low two more bits
    baud_rate = 2'b01; parity_type = 2'b00;
    n = done_count;
    push_exp(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, DIV4800, 1'b0, 1'b0, 1'b0);
    saw_active = 1'b0;
    data_rx = 1'b0;
    repeat (32 * DIV4800) begin
      @(negedge clock);
      saw_active |= active_flag;
    end
    chk("t4_active_while_low", 32'(saw_active), 32'h0);
    chk("t4_done_count", 32'(done_count), 32'(n + 1));
    drive_bit(1'b1, DIV4800);
    parity_type = 2'b11;
    n = done_count;
    push_exp(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, DIV4800, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, DIV4800);
    chk("t4b_done_count", 32'(done_count), 32'(n + 1));
    chk_range("t4b_latency", last_done_cyc - start_cyc, 152 * DIV4800, 153 * DIV4800 + 5);

    // 9600 short low glitch: false start, outputs held
    baud_rate = 2'b10; parity_type = 2'b00;
    n = done_count;
    data_rx = 1'b0;
    repeat (6) @(negedge clock);
    data_rx = 1'b1;
    saw_active = 1'b0;
    repeat (48 * DIV9600) begin
      @(negedge clock);
      saw_active |= active_flag;
    end
    chk("t5_active_never", 32'(saw_active), 32'h0);
    chk("t5_no_done", 32'(done_count), 32'(n));
    chk("t5_data_held", 32'(data_out), 32'h3C);

    // 2400 none: reset in the middle of data bit 4, then a full 0xC3 frame
    baud_rate = 2'b00; parity_type = 2'b00;
    c3 = 8'hC3;
    n = done_count;
    drive_bit(1'b0, DIV2400);
    for (int i = 0; i < 4; i++) drive_bit(c3[i], DIV2400);
    data_rx = c3[4];
    repeat (8 * DIV2400) @(negedge clock);
    chk("t6_active_before_reset", 32'(active_flag), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    chk_idle_outputs("t6_reset");
    reset = 1'b0;
    data_rx = 1'b1;
    drive_bit(1'b1, DIV2400);
    drive_bit(1'b1, DIV2400);
    chk("t6_no_done", 32'(done_count), 32'(n));
    push_exp(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, DIV2400, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, DIV2400);
    chk("t6_done_count", 32'(done_count), 32'(n + 1));

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
